mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle main control unit for the MIPS core; it sits on the issuing side of the ALU interface.
- Decodes the latched instruction's opcode and funct fields.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives alu_ctrl and the datapath mux/enable strobes, consumes the ALU compare flag for beq, and handshakes with instruction/data memory through a req/ready pair.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before bus_err; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- alu_zero  in  1  ALU compare flag: 1 when a != b, 0 when a == b
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write strobe
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- reg_we  out  1  register file write
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU operand a: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU operand b: 0 = rt, 1 = 4, 2 = ext(imm), 3 = sext(imm) << 2
- ext_zero  out  1  1 = zero-extend imm (ori), 0 = sign-extend
- alu_ctrl  out  6  ALU operation code, using the shared op macros
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- bus_err  out  1  one-cycle pulse on a memory timeout

Behaviour:
- State register: 4 bits. States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
- Reset:
  - rst asserted at any time forces state to IDLE immediately, including mid-access.
  - Wait counter clears.
  - All outputs are 0, with alu_ctrl = 6'b0. A strobe never stays high during reset.
- Output defaults: every output not listed for a state is 0.
- IDLE: all outputs 0; goes to FETCH on the next edge.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=addu_op.
  - When mem_ready=1 (Mealy): ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=addu_op (branch target goes to ALUOut). Next state by opcode:
  - 000000 → EXEC_R if funct is supported, else illegal
  - 001101 (ori), 001111 (lui), 001001 (addiu) → EXEC_I
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - Any other opcode → illegal
  - Illegal path: pulse illegal_op and return to FETCH. PC is already advanced; no register or memory write occurs.
- EXEC_R: alu_src_a=1, alu_src_b=0. Funct mapping: 100001→addu_op, 100011→subu_op, 100000→add_op, 100100→and_op, 100101→or_op, 101010→slt_op. Then go to ALU_WB with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=2.
  - ori: or_op with ext_zero=1.
  - lui: lui_op.
  - addiu: addu_op.
  - Then go to ALU_WB with reg_dst=0.
- ALU_WB: reg_we=1, mem_to_reg=0, reg_dst held from the exec class; instr_done=1; go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=addu_op; go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1; wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready. On the mem_ready cycle pulse instr_done and go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_ctrl=subu_op.
  - If alu_zero==0 (operands equal): pc_we=1, pc_src=1.
  - instr_done=1; go to FETCH.
- JUMP: pc_we=1, pc_src=2, instr_done=1; go to FETCH.
- Opcode/funct sampling: opcode and funct are sampled every cycle from the IR. The IR is stable from DECODE until the next FETCH completes. The alu_ctrl class for EXEC states is held in a 2-bit registered flag (R / I-ori / I-lui / I-addiu) captured in DECODE.
- Timeout:
  - The wait counter increments each cycle that mem_req=1 and mem_ready=0, and clears when mem_ready=1 or on a state change.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: pulse bus_err and go to IDLE; no write strobe is issued that cycle.
  - mem_ready arriving on the same cycle as the count reaching MEM_TIMEOUT: mem_ready wins and the access completes.
- mem_ready outside a request is ignored.

Decomposition:
- Shared include holds the alu_ctrl op macros (already shared with the ALU) plus new opcode/funct constants and state encodings.
- Optional sub-module mc_wait_timer (counter plus timeout compare) instantiated once; all remaining logic is the FSM.

Test Plan:
- Reset: rst=1 mid-MEM_RD with mem_req=1 → the same cycle mem_req=0 and all strobes 0; after release, IDLE then FETCH with mem_req=1.
- R-type: fetch with mem_ready=1 on cycle 2, opcode=0, funct=100011 → EXEC_R shows alu_ctrl=subu_op with alu_src_a=1, alu_src_b=0; ALU_WB shows reg_we=1, reg_dst=1, instr_done=1; FETCH again after 4 cycles total.
- beq: alu_zero=0 → BRANCH shows pc_we=1, pc_src=1; repeat with alu_zero=1 → pc_we=0; instr_done pulses in both cases.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req held 4 cycles, then MEM_WB with reg_we=1, mem_to_reg=1; sw → mem_we=1 only while in MEM_WR.
- ori vs lui: ori → alu_ctrl=or_op, ext_zero=1; lui → alu_ctrl=lui_op, ext_zero=0, alu_src_b=2.
- Error paths:
  - Timeout: MEM_TIMEOUT=16 with mem_ready never asserted in FETCH → bus_err pulses after 16 wait cycles, then IDLE.
  - Illegal: opcode=111111 → illegal_op pulse in DECODE, no reg_we, return to FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: ALU op codes, opcode/funct values, state encodings.
// Pure definitions; no latency or backpressure of its own.
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] ADD_OP  = 6'h01;
  localparam logic [5:0] ADDU_OP = 6'h02;
  localparam logic [5:0] SUBU_OP = 6'h03;
  localparam logic [5:0] AND_OP  = 6'h04;
  localparam logic [5:0] OR_OP   = 6'h05;
  localparam logic [5:0] SLT_OP  = 6'h06;
  localparam logic [5:0] LUI_OP  = 6'h07;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_ORI   = 2'd1,
    CLS_LUI   = 2'd2,
    CLS_ADDIU = 2'd3
  } exec_cls_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] funct_alu_op(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return ADD_OP;
      FN_SUBU: return SUBU_OP;
      FN_AND:  return AND_OP;
      FN_OR:   return OR_OP;
      FN_SLT:  return SLT_OP;
      default: return ADDU_OP;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts memory wait cycles and flags a timeout when the count reaches MEM_TIMEOUT (0 disables).
// Timeout is combinational on the current wait cycle; a same-cycle ready suppresses it.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic clr,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;
  logic          wait_cyc;

  assign wait_cyc = req & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (req && ready)) begin
      cnt <= '0;
    end else if (wait_cyc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = (MEM_TIMEOUT > 0) && wait_cyc && (cnt == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/memory/writeback sequencing, 1 state per cycle.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; a stall reaching MEM_TIMEOUT raises bus_err and drops to IDLE.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [5:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  exec_cls_t  cls;
  exec_cls_t  dec_cls;
  logic [3:0] dec_nxt;
  logic       dec_legal;
  logic       req_state;
  logic       timeout;

  assign req_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (req_state),
    .ready   (mem_ready),
    .clr     (state_nxt != state),
    .timeout (timeout)
  );

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = CLS_R;
    dec_nxt   = S_FETCH;
    case (opcode)
      OPC_RTYPE: begin
        dec_legal = funct_ok(funct);
        dec_nxt   = S_EXEC_R;
      end
      OPC_ORI: begin
        dec_cls = CLS_ORI;
        dec_nxt = S_EXEC_I;
      end
      OPC_LUI: begin
        dec_cls = CLS_LUI;
        dec_nxt = S_EXEC_I;
      end
      OPC_ADDIU: begin
        dec_cls = CLS_ADDIU;
        dec_nxt = S_EXEC_I;
      end
      OPC_LW, OPC_SW: dec_nxt = S_MEM_ADDR;
      OPC_BEQ:        dec_nxt = S_BRANCH;
      OPC_J:          dec_nxt = S_JUMP;
      default:        dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cls   <= CLS_R;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        cls <= dec_cls;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    alu_ctrl   = 6'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_ctrl  = ADDU_OP;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b  = 2'd3;
        alu_ctrl   = ADDU_OP;
        illegal_op = ~dec_legal;
        state_nxt  = dec_nxt;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu_op(funct);
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (cls)
          CLS_ORI: begin
            alu_ctrl = OR_OP;
            ext_zero = 1'b1;
          end
          CLS_LUI: alu_ctrl = LUI_OP;
          default: alu_ctrl = ADDU_OP;
        endcase
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (cls == CLS_R);
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = ADDU_OP;
        state_nxt = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEM_WB;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else if (timeout) begin
          // Abandoned write must not leave a strobe on the bus.
          mem_we    = 1'b0;
          bus_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = SUBU_OP;
        instr_done = 1'b1;
        if (!alu_zero) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction expected output traces built from instruction semantics.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam int TO = 16;
  localparam int K_ILL = 0, K_R = 1, K_ORI = 2, K_LUI = 3, K_ADDIU = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [5:0] alu_ctrl;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_err;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a, ext_zero;
  logic       instr_done, illegal_op, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_ctrl;

  int checks = 0;
  int failures = 0;

  ov_t        exp_q[$];
  logic       rdy_q[$];
  logic       z_q[$];
  logic [5:0] op_q[$];
  logic [5:0] fn_q[$];

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic ov_t sample();
    ov_t o;
    o.mem_req = mem_req;     o.mem_we = mem_we;         o.iord = iord;
    o.ir_we = ir_we;         o.pc_we = pc_we;           o.pc_src = pc_src;
    o.reg_we = reg_we;       o.reg_dst = reg_dst;       o.mem_to_reg = mem_to_reg;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;   o.ext_zero = ext_zero;
    o.alu_ctrl = alu_ctrl;   o.instr_done = instr_done; o.illegal_op = illegal_op;
    o.bus_err = bus_err;
    return o;
  endfunction

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010: return K_R;
          default: return K_ILL;
        endcase
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b001001: return K_ADDIU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] exp_r_op(logic [5:0] fn);
    case (fn)
      6'b100000: return ADD_OP;
      6'b100011: return SUBU_OP;
      6'b100100: return AND_OP;
      6'b100101: return OR_OP;
      6'b101010: return SLT_OP;
      default:   return ADDU_OP;
    endcase
  endfunction

  function automatic void push(ov_t e, logic r, logic [5:0] op, logic [5:0] fn, logic z);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    op_q.push_back(op);
    fn_q.push_back(fn);
    z_q.push_back(z);
  endfunction

  // Fetch: IR contents are meaningless until the fetch completes, so drive junk.
  function automatic void model_fetch(int waits);
    ov_t e = '0;
    e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_ctrl = ADDU_OP;
    for (int i = 0; i < waits; i++) push(e, 1'b0, 6'($urandom), 6'($urandom), 1'($urandom));
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(e, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
  endfunction

  function automatic void model_decode(logic [5:0] op, logic [5:0] fn);
    ov_t e = '0;
    e.alu_src_b = 2'd3; e.alu_ctrl = ADDU_OP;
    e.illegal_op = (classify(op, fn) == K_ILL);
    push(e, 1'($urandom), op, fn, 1'($urandom));
  endfunction

  function automatic void model_mem_addr(logic [5:0] op, logic [5:0] fn);
    ov_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_ctrl = ADDU_OP;
    push(e, 1'($urandom), op, fn, 1'($urandom));
  endfunction

  function automatic void model_instr(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
    ov_t e;
    int  k = classify(op, fn);
    model_fetch(fw);
    model_decode(op, fn);
    e = '0;
    case (k)
      K_R: begin
        e.alu_src_a = 1'b1; e.alu_ctrl = exp_r_op(fn);
        push(e, 1'($urandom), op, fn, 1'($urandom));
        e = '0; e.reg_we = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
        push(e, 1'($urandom), op, fn, 1'($urandom));
      end
      K_ORI, K_LUI, K_ADDIU: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        e.alu_ctrl = (k == K_ORI) ? OR_OP : (k == K_LUI) ? LUI_OP : ADDU_OP;
        e.ext_zero = (k == K_ORI);
        push(e, 1'($urandom), op, fn, 1'($urandom));
        e = '0; e.reg_we = 1'b1; e.instr_done = 1'b1;
        push(e, 1'($urandom), op, fn, 1'($urandom));
      end
      K_LW: begin
        model_mem_addr(op, fn);
        e.mem_req = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, op, fn, 1'($urandom));
        push(e, 1'b1, op, fn, 1'($urandom));
        e = '0; e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
        push(e, 1'($urandom), op, fn, 1'($urandom));
      end
      K_SW: begin
        model_mem_addr(op, fn);
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push(e, 1'b0, op, fn, 1'($urandom));
        e.instr_done = 1'b1;
        push(e, 1'b1, op, fn, 1'($urandom));
      end
      K_BEQ: begin
        e.alu_src_a = 1'b1; e.alu_ctrl = SUBU_OP; e.instr_done = 1'b1;
        e.pc_we = ~z; e.pc_src = z ? 2'd0 : 2'd1;
        push(e, 1'($urandom), op, fn, z);
      end
      K_J: begin
        e.pc_we = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
        push(e, 1'($urandom), op, fn, 1'($urandom));
      end
      default: ;
    endcase
  endfunction

  // A stalled access: TO wait cycles pass quietly, the next one raises bus_err, then IDLE.
  function automatic void model_timeout(ov_t w, logic [5:0] op, logic [5:0] fn);
    ov_t e = w;
    for (int i = 0; i < TO; i++) push(e, 1'b0, op, fn, 1'($urandom));
    e.bus_err = 1'b1;
    e.mem_we = 1'b0;
    push(e, 1'b0, op, fn, 1'($urandom));
    push('0, 1'($urandom), op, fn, 1'($urandom));
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic r, input logic z,
                      output ov_t o);
    opcode = op; funct = fn; mem_ready = r; alu_zero = z;
    @(negedge clk);
    o = sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    mem_ready = 1'b1; opcode = 6'b100011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = sample();
      checks++;
      if (o !== ov_t'(0)) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", o, ov_t'(0));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push('0, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
    model_instr(6'b000000, 6'b100001, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_r_type();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    logic [5:0] fns [6] = '{6'b100011, 6'b100001, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
    model_instr(6'b000000, 6'b100011, 1'b0, 1, 0);
    for (int i = 0; i < 6; i++) model_instr(6'b000000, fns[i], 1'($urandom), $urandom_range(0, 3), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL r_type cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_i_type();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    model_instr(6'b001101, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b001111, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b001001, 6'($urandom), 1'b0, 2, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL i_type cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_load_store();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    model_instr(6'b100011, 6'($urandom), 1'b0, 0, 3);
    model_instr(6'b101011, 6'($urandom), 1'b0, 1, 2);
    model_instr(6'b101011, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b100011, 6'($urandom), 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL load_store cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_branch_jump();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    model_instr(6'b000100, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
    model_instr(6'b000010, 6'($urandom), 1'b0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL branch_jump cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    model_instr(6'b111111, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    model_instr(6'b000011, 6'($urandom), 1'b0, 0, 0);
    model_instr(6'b001101, 6'($urandom), 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_timeout();
    ov_t o, e, w;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    w = '0; w.mem_req = 1'b1; w.alu_src_b = 2'd1; w.alu_ctrl = ADDU_OP;
    model_timeout(w, 6'($urandom), 6'($urandom));
    model_instr(6'b001001, 6'($urandom), 1'b0, TO, 0);
    model_fetch(0); model_decode(6'b100011, 6'd0); model_mem_addr(6'b100011, 6'd0);
    w = '0; w.mem_req = 1'b1; w.iord = 1'b1;
    model_timeout(w, 6'b100011, 6'd0);
    model_fetch(0); model_decode(6'b101011, 6'd0); model_mem_addr(6'b101011, 6'd0);
    w.mem_we = 1'b1;
    model_timeout(w, 6'b101011, 6'd0);
    model_instr(6'b101011, 6'($urandom), 1'b0, 0, TO);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_access();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    model_fetch(0); model_decode(6'b100011, 6'd0); model_mem_addr(6'b100011, 6'd0);
    e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
    push(e, 1'b0, 6'b100011, 6'd0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_setup cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
    // Still in MEM_RD waiting; assert reset between edges and look within the same cycle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 o = sample();
    checks++;
    if (o !== ov_t'(0)) begin
      failures++;
      $display("FAIL mid_reset_async got=%h exp=%h", o, ov_t'(0));
    end
    mem_ready = 1'b1;
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== ov_t'(0)) begin
      failures++;
      $display("FAIL mid_reset_held got=%h exp=%h", o, ov_t'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push('0, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
    model_instr(6'b100011, 6'($urandom), 1'b0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_reset_resume cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    ov_t o, e;
    logic [5:0] op, fn;
    logic r, z;
    int cyc = 0;
    logic [5:0] fns [6] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] ops [7] = '{6'b001101, 6'b001111, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    begin op = 6'b000000; fn = fns[$urandom_range(0, 5)]; end
        2:       begin op = 6'b000000; fn = 6'($urandom); end
        3:       begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = ops[$urandom_range(0, 6)]; fn = 6'($urandom); end
      endcase
      model_instr(op, fn, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
      r = rdy_q.pop_front(); z = z_q.pop_front();
      step(op, fn, r, z, o);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d op=%b fn=%b got=%h exp=%h", cyc, op, fn, o, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
